// File: rtl/seq_detector_mealy_if.sv
// Stream/status bundle of the serial sequence detector: the stream side drives
// en/w/overlap/clr_cnt, the detector returns the match flag and counter.
interface seq_detector_mealy_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             w;
    logic             overlap;
    logic             clr_cnt;
    logic             z;
    logic             z_q;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output en,
        output w,
        output overlap,
        output clr_cnt,
        input  z,
        input  z_q,
        input  match_cnt,
        input  cnt_sat
    );

    modport slave (
        input  en,
        input  w,
        input  overlap,
        input  clr_cnt,
        output z,
        output z_q,
        output match_cnt,
        output cnt_sat
    );
endinterface

// File: rtl/seq_detector_mealy.sv
// Mealy serial detector for an arbitrary N-bit pattern (KMP automaton) with
// overlap select, clock enable, saturating match counter and registered flag.
module seq_detector_mealy #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter int             CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    seq_detector_mealy_if.slave  bus
);

    localparam int SW = (N <= 2) ? 1 : $clog2(N);
    localparam int NS = 1 << SW;

    // Bit i of the received pattern (i=0 is the first bit on the wire).
    function automatic logic pat_bit(input int i);
        return PATTERN[N-1-i];
    endfunction

    // Longest proper prefix of the pattern that is a suffix of prefix(s)+b.
    // Only called for s in 0..N-1 with the full-match case excluded by the FSM.
    function automatic int delta_fn(input int s, input int b);
        int   best;
        int   j;
        logic ok;
        logic t_bit;
        best = 0;
        for (int k = 1; k <= N - 1; k++) begin
            if (k <= s + 1) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    j     = s + 1 - k + i;
                    t_bit = (j == s) ? (b != 0) : pat_bit(j);
                    if (t_bit != pat_bit(i)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

    // Longest proper border of the whole pattern: restart point after an
    // overlapping match.
    function automatic int border_fn();
        int   best;
        logic ok;
        best = 0;
        for (int k = 1; k <= N - 1; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (pat_bit(i) != pat_bit(N - k + i)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = k;
            end
        end
        return best;
    endfunction

    localparam int           BORDER   = border_fn();
    localparam logic [SW-1:0] BORDER_S = SW'(BORDER);
    localparam logic [SW-1:0] LAST_S   = SW'(N - 1);

    // Next-state tables, one entry per encoding; unused encodings map to 0.
    logic [SW-1:0] next0 [NS];
    logic [SW-1:0] next1 [NS];

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_table
            if (gi < N) begin : g_used
                localparam int D0 = delta_fn(gi, 0);
                localparam int D1 = delta_fn(gi, 1);
                assign next0[gi] = SW'(D0);
                assign next1[gi] = SW'(D1);
            end else begin : g_unused
                assign next0[gi] = '0;
                assign next1[gi] = '0;
            end
        end
    endgenerate

    logic [SW-1:0]    state_reg;
    logic [SW-1:0]    state_next;
    logic             match;
    logic             z_q_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_reg;
    logic             sat_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= '0;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        match      = 1'b0;
        state_next = state_reg;
        if (bus.en) begin
            if ((state_reg == LAST_S) && (bus.w == PATTERN[0])) begin
                match      = 1'b1;
                state_next = bus.overlap ? BORDER_S : '0;
            end else if (bus.w) begin
                state_next = next1[state_reg];
            end else begin
                state_next = next0[state_reg];
            end
        end
    end

    // A clear wins over a coincident match; the match is simply not counted.
    always_comb begin
        cnt_next = cnt_reg;
        sat_next = sat_reg;
        if (bus.clr_cnt) begin
            cnt_next = '0;
            sat_next = 1'b0;
        end else begin
            if (match && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
            sat_next = sat_reg | (cnt_next == {CNT_W{1'b1}});
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            z_q_reg <= 1'b0;
            cnt_reg <= '0;
            sat_reg <= 1'b0;
        end else begin
            z_q_reg <= match;
            cnt_reg <= cnt_next;
            sat_reg <= sat_next;
        end
    end

    assign bus.z         = match;
    assign bus.z_q       = z_q_reg;
    assign bus.match_cnt = cnt_reg;
    assign bus.cnt_sat   = sat_reg;

endmodule

// File: tb/tb_seq_detector_mealy.sv
// Directed bench for seq_detector_mealy (PATTERN=1101): an 8-bit counter
// instance and a 2-bit counter instance share one stimulus stream.
module tb_seq_detector_mealy;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    seq_detector_mealy_if #(.CNT_W(8)) bus_a ();
    seq_detector_mealy_if #(.CNT_W(2)) bus_b ();

    assign bus_b.en      = bus_a.en;
    assign bus_b.w       = bus_a.w;
    assign bus_b.overlap = bus_a.overlap;
    assign bus_b.clr_cnt = bus_a.clr_cnt;

    seq_detector_mealy #(.N(4), .PATTERN(4'b1101), .CNT_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_a)
    );

    seq_detector_mealy #(.N(4), .PATTERN(4'b1101), .CNT_W(2)) dut_sat (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d need %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One bit: z is checked combinationally, z_q just after the edge.
    task automatic step(input logic e, input logic b, input logic ez);
        bus_a.en = e;
        bus_a.w  = b;
        #1;
        chk("z", bus_a.z, ez);
        @(posedge clk);
        #1;
        chk("z_q", bus_a.z_q, ez);
    endtask

    // bits[len-1] is sent first; zexp holds the expected z per bit likewise.
    task automatic run_seq(input logic [15:0] bits, input int len, input logic [15:0] zexp);
        for (int i = len - 1; i >= 0; i--) begin
            step(1'b1, bits[i], zexp[i]);
        end
    endtask

    task automatic do_reset();
        #2 resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_cnt", bus_a.match_cnt, 0);
        chk("rst_zq", bus_a.z_q, 0);
        resetn = 1'b1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        resetn        = 1'b0;
        bus_a.en      = 1'b0;
        bus_a.w       = 1'b0;
        bus_a.overlap = 1'b1;
        bus_a.clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_z", bus_a.z, 0);
        chk("rst_zq", bus_a.z_q, 0);
        chk("rst_cnt", bus_a.match_cnt, 0);
        chk("rst_sat", bus_a.cnt_sat, 0);
        resetn = 1'b1;

        // overlapping: 1101101 matches on bits 4 and 7
        bus_a.overlap = 1'b1;
        run_seq(16'b1101101, 7, 16'b0001001);
        chk("t1_cnt", bus_a.match_cnt, 2);

        // non-overlapping: one match, then s=1 shows as a match on probe 101
        do_reset();
        bus_a.overlap = 1'b0;
        run_seq(16'b1101101, 7, 16'b0001000);
        chk("t2_cnt", bus_a.match_cnt, 1);
        run_seq(16'b101, 3, 16'b001);
        chk("t2_probe_cnt", bus_a.match_cnt, 2);

        // 111011: third 1 keeps s=2, match lands on bit 5
        do_reset();
        bus_a.overlap = 1'b1;
        run_seq(16'b111011, 6, 16'b000010);
        chk("t3_cnt", bus_a.match_cnt, 1);

        // enable gating
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("t4_hold_cnt", bus_a.match_cnt, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t4_cnt", bus_a.match_cnt, 1);
        run_seq(16'b110, 3, 16'b000);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t4b_cnt", bus_a.match_cnt, 2);

        // async reset mid-cycle with a match pending on w
        run_seq(16'b110, 3, 16'b000);
        bus_a.en = 1'b1;
        bus_a.w  = 1'b1;
        #1;
        chk("t5_pre_z", bus_a.z, 1);
        resetn = 1'b0;
        #1;
        chk("t5_z", bus_a.z, 0);
        chk("t5_cnt", bus_a.match_cnt, 0);
        #1 resetn = 1'b1;
        #1;
        chk("t5_after_z", bus_a.z, 0);
        @(posedge clk);
        #1;
        run_seq(16'b1101, 4, 16'b0001);
        #1 resetn = 1'b0;
        #1;
        chk("t5_zq", bus_a.z_q, 0);
        chk("t5_cnt2", bus_a.match_cnt, 0);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        // saturation on the 2-bit counter, then clear on a match cycle
        do_reset();
        bus_a.overlap = 1'b1;
        run_seq(16'b1101, 4, 16'b0001);
        chk("t6_cnt1", bus_b.match_cnt, 1);
        chk("t6_sat1", bus_b.cnt_sat, 0);
        run_seq(16'b101, 3, 16'b001);
        chk("t6_cnt2", bus_b.match_cnt, 2);
        chk("t6_sat2", bus_b.cnt_sat, 0);
        run_seq(16'b101, 3, 16'b001);
        chk("t6_cnt3", bus_b.match_cnt, 3);
        chk("t6_sat3", bus_b.cnt_sat, 1);
        run_seq(16'b101, 3, 16'b001);
        chk("t6_cnt4", bus_b.match_cnt, 3);
        chk("t6_sat4", bus_b.cnt_sat, 1);
        chk("t6_wide_cnt", bus_a.match_cnt, 4);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        bus_a.clr_cnt = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        bus_a.clr_cnt = 1'b0;
        chk("t6_clr_cnt", bus_b.match_cnt, 0);
        chk("t6_clr_sat", bus_b.cnt_sat, 0);
        chk("t6_clr_wide", bus_a.match_cnt, 0);
        run_seq(16'b101, 3, 16'b001);
        chk("t6_post_cnt", bus_b.match_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
